// File: rtl/mem_responder.sv
// mem_responder
//   Serves per-channel LSU read/write requests against a single internal
//   memory, one request at a time, with round-robin arbitration and a fixed
//   grant-to-ready latency. A side preload port can write the memory at any
//   time and takes precedence over a same-address write commit.
//
// Ports
//   clk            rising-edge clock for all logic
//   reset          asynchronous active-low reset (memory contents preserved)
//   read_valid     per-channel read request, held until read_ready
//   read_address   per-channel read address, channel c at [c*ADDR_BITS +: ADDR_BITS]
//   read_ready     per-channel one-cycle read completion pulse
//   read_data      per-channel read data, held until that channel's next read
//   write_valid    per-channel write request, held until write_ready
//   write_address  per-channel write address
//   write_data     per-channel write data
//   write_ready    per-channel one-cycle write completion pulse
//   load_en        preload strobe
//   load_addr      preload address
//   load_data      preload data
//   busy           high whenever a request is in flight (FSM not IDLE)
module mem_responder #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int LATENCY      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready,
  input  logic                              load_en,
  input  logic [ADDR_BITS-1:0]              load_addr,
  input  logic [DATA_BITS-1:0]              load_data,
  output logic                              busy
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [3:0]      LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND,
    RELEASE
  } state_t;

  state_t                state_reg,  state_next;
  logic [CH_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [3:0]            count_reg,  count_next;
  logic [CH_W-1:0]       chan_reg,   chan_next;
  logic                  op_wr_reg,  op_wr_next;
  logic [ADDR_BITS-1:0]  addr_reg,   addr_next;
  logic [DATA_BITS-1:0]  wdata_reg,  wdata_next;

  logic [NUM_CHANNELS-1:0] eligible;
  logic                    grant_found;
  logic [CH_W-1:0]         grant_chan;
  logic                    served_valid;
  logic                    commit;
  logic                    capture;

  logic [ADDR_BITS-1:0] rd_addr_arr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] wr_addr_arr [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wr_data_arr [NUM_CHANNELS];

  logic [DATA_BITS-1:0] mem [DEPTH];

  assign eligible = read_valid | write_valid;
  assign busy     = (state_reg != IDLE);

  // Round-robin pick: first look at channels at or above rr_ptr, then wrap
  // around to the channels below it.
  always_comb begin
    grant_found = 1'b0;
    grant_chan  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!grant_found && eligible[c] && (CH_W'(c) >= rr_ptr_reg)) begin
        grant_found = 1'b1;
        grant_chan  = CH_W'(c);
      end
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!grant_found && eligible[c]) begin
        grant_found = 1'b1;
        grant_chan  = CH_W'(c);
      end
    end
  end

  // The request that was served; RELEASE waits for this one to drop so a
  // held-high valid is not served twice.
  assign served_valid = op_wr_reg ? write_valid[chan_reg] : read_valid[chan_reg];

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    count_next  = count_reg;
    chan_next   = chan_reg;
    op_wr_next  = op_wr_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    commit      = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          chan_next   = grant_chan;
          // A write wins over a simultaneous read on the same channel; the
          // read stays pending and is picked up in a later round.
          op_wr_next  = write_valid[grant_chan];
          addr_next   = write_valid[grant_chan] ? wr_addr_arr[grant_chan]
                                                : rd_addr_arr[grant_chan];
          wdata_next  = wr_data_arr[grant_chan];
          rr_ptr_next = (grant_chan == LAST_CH) ? '0 : grant_chan + CH_W'(1);
          count_next  = LAT_LOAD;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (count_reg == 4'd0) begin
          commit     = op_wr_reg;
          capture    = !op_wr_reg;
          state_next = RESPOND;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESPOND: state_next = RELEASE;
      RELEASE: begin
        if (!served_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      count_reg  <= '0;
      chan_reg   <= '0;
      op_wr_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      count_reg  <= count_next;
      chan_reg   <= chan_next;
      op_wr_reg  <= op_wr_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

  // Memory is deliberately outside the reset domain. The preload assignment
  // comes last so it overrides a write commit to the same address.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[addr_reg] <= wdata_reg;
    end
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [DATA_BITS-1:0] rdata_reg;

      assign rd_addr_arr[gi] = read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_arr[gi] = write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_data_arr[gi] = write_data[gi*DATA_BITS +: DATA_BITS];

      // Captures the pre-edge memory content, so a same-edge preload is not
      // forwarded into the read result.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rdata_reg <= '0;
        end else if (capture && (chan_reg == CH_W'(gi))) begin
          rdata_reg <= mem[addr_reg];
        end
      end

      assign read_data[gi*DATA_BITS +: DATA_BITS] = rdata_reg;
      assign read_ready[gi]  = (state_reg == RESPOND) && !op_wr_reg && (chan_reg == CH_W'(gi));
      assign write_ready[gi] = (state_reg == RESPOND) &&  op_wr_reg && (chan_reg == CH_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers push expected responses into a
// queue, a negedge monitor pops and compares whenever a ready pulse appears.
module tb_mem_responder;

  localparam int NC  = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   read_valid;
  logic [NC*AB-1:0] read_address;
  logic [NC-1:0]   read_ready;
  logic [NC*DB-1:0] read_data;
  logic [NC-1:0]   write_valid;
  logic [NC*AB-1:0] write_address;
  logic [NC*DB-1:0] write_data;
  logic [NC-1:0]   write_ready;
  logic            load_en;
  logic [AB-1:0]   load_addr;
  logic [DB-1:0]   load_data;
  logic            busy;

  mem_responder #(
    .NUM_CHANNELS(NC),
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_valid(read_valid),
    .read_address(read_address),
    .read_ready(read_ready),
    .read_data(read_data),
    .write_valid(write_valid),
    .write_address(write_address),
    .write_data(write_data),
    .write_ready(write_ready),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    bit         wr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    int   n;
    exp_t e;
    if (reset === 1'b1) begin
      n = $countones({read_ready, write_ready});
      if (n > 1) check("one_ready_per_cycle", n, 1);
      for (int c = 0; c < NC; c++) begin
        if (read_ready[c] || write_ready[c]) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp: ch%0d rd_ready=%b wr_ready=%b, none required",
                     c, read_ready[c], write_ready[c]);
          end else begin
            e = exp_q.pop_front();
            $display("resp ch=%0d %s data=0x%02h", c, write_ready[c] ? "write" : "read",
                     read_data[c*DB +: DB]);
            check("resp_chan", c, e.ch);
            check("resp_op", {31'd0, write_ready[c]}, {31'd0, e.wr});
            if (!e.wr) check("resp_data", read_data[c*DB +: DB], e.data);
          end
        end
      end
    end
  end

  task automatic wait_ready(input int ch, input bit wr, output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (wr ? write_ready[ch] : read_ready[ch]) break;
      if (n >= 50) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0) begin
      @(posedge clk); #1;
      n++;
      if (n >= 50) begin
        check("idle_timeout", {31'd0, busy}, 0);
        break;
      end
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic do_read(input int ch, input logic [7:0] a, input logic [7:0] d);
    int n;
    wait_idle();
    exp_q.push_back('{ch, 1'b0, d});
    read_address[ch*AB +: AB] = a;
    read_valid[ch] = 1'b1;
    @(posedge clk); #1;
    check("busy_after_grant", {31'd0, busy}, 1);
    wait_ready(ch, 1'b0, n);
    check("read_latency", n, LAT);
    read_valid[ch] = 1'b0;
    @(posedge clk); #1;
    check("read_ready_one_cycle", {31'd0, read_ready[ch]}, 0);
    wait_idle();
  endtask

  task automatic do_write(input int ch, input logic [7:0] a, input logic [7:0] d);
    int n;
    wait_idle();
    exp_q.push_back('{ch, 1'b1, 8'h00});
    write_address[ch*AB +: AB] = a;
    write_data[ch*DB +: DB] = d;
    write_valid[ch] = 1'b1;
    @(posedge clk); #1;
    check("busy_after_grant", {31'd0, busy}, 1);
    wait_ready(ch, 1'b1, n);
    check("write_latency", n, LAT);
    write_valid[ch] = 1'b0;
    @(posedge clk); #1;
    check("write_ready_one_cycle", {31'd0, write_ready[ch]}, 0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    read_valid = '0; read_address = '0; write_valid = '0;
    write_address = '0; write_data = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    reset = 1'b0;
    #2;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_read_ready", {28'd0, read_ready}, 0);
    check("reset_write_ready", {28'd0, write_ready}, 0);
    check("reset_read_data", read_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Basic preload + read on ch0.
    do_load(8'h10, 8'hAB);
    do_read(0, 8'h10, 8'hAB);

    // Write on ch2, read back on ch1; ch0's data must be untouched.
    do_write(2, 8'h20, 8'h5C);
    do_read(1, 8'h20, 8'h5C);
    check("ch0_data_held", read_data[0 +: DB], 8'hAB);

    // Address change after grant is ignored.
    wait_idle();
    exp_q.push_back('{3, 1'b0, 8'hAB});
    read_address[3*AB +: AB] = 8'h10;
    read_valid[3] = 1'b1;
    @(posedge clk); #1;
    read_address[3*AB +: AB] = 8'h20;
    wait_ready(3, 1'b0, n);
    read_valid[3] = 1'b0;
    wait_idle();

    // Read and write together on ch0: write first, then the pending read.
    exp_q.push_back('{0, 1'b1, 8'h00});
    exp_q.push_back('{0, 1'b0, 8'h3C});
    read_address[0 +: AB] = 8'h60;
    write_address[0 +: AB] = 8'h60;
    write_data[0 +: DB] = 8'h3C;
    read_valid[0] = 1'b1;
    write_valid[0] = 1'b1;
    wait_ready(0, 1'b1, n);
    write_valid[0] = 1'b0;
    wait_ready(0, 1'b0, n);
    read_valid[0] = 1'b0;
    wait_idle();

    // Round robin from rr_ptr=0: reset, then all four channels at once.
    do_load(8'h50, 8'hA0);
    do_load(8'h51, 8'hB1);
    do_load(8'h52, 8'hC2);
    do_load(8'h53, 8'hD3);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < NC; c++) begin
      read_address[c*AB +: AB] = 8'h50 + 8'(c);
    end
    exp_q.push_back('{0, 1'b0, 8'hA0});
    exp_q.push_back('{1, 1'b0, 8'hB1});
    exp_q.push_back('{2, 1'b0, 8'hC2});
    exp_q.push_back('{3, 1'b0, 8'hD3});
    read_valid = 4'hF;
    n = 0;
    while (read_valid != 4'h0) begin
      @(posedge clk); #1;
      n++;
      for (int c = 0; c < NC; c++) begin
        if (read_ready[c]) read_valid[c] = 1'b0;
      end
      if (n >= 100) begin
        check("rr_timeout", {28'd0, read_valid}, 0);
        read_valid = '0;
      end
    end
    wait_idle();

    // ch1 holds its read valid three cycles past ready: one pulse only.
    exp_q.push_back('{1, 1'b0, 8'hAB});
    read_address[1*AB +: AB] = 8'h10;
    read_valid[1] = 1'b1;
    wait_ready(1, 1'b0, n);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_busy_in_release", {31'd0, busy}, 1);
      check("hold_no_second_ready", {31'd0, read_ready[1]}, 0);
    end
    read_valid[1] = 1'b0;
    wait_idle();

    // Reset while busy on a write aborts it.
    do_load(8'h30, 8'h11);
    write_address[0 +: AB] = 8'h30;
    write_data[0 +: DB] = 8'h77;
    write_valid[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_before", {31'd0, busy}, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_busy_now", {31'd0, busy}, 0);
    check("abort_write_ready", {28'd0, write_ready}, 0);
    check("abort_read_data", read_data, 0);
    repeat (3) @(posedge clk);
    #1 write_valid[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    do_read(2, 8'h30, 8'h11);

    // Preload and write commit to 0x40 on the same edge: preload wins.
    wait_idle();
    exp_q.push_back('{3, 1'b1, 8'h00});
    write_address[3*AB +: AB] = 8'h40;
    write_data[3*DB +: DB] = 8'h22;
    write_valid[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 8'h40; load_data = 8'h99;
    @(posedge clk); #1;
    load_en = 1'b0;
    check("collision_write_ready", {31'd0, write_ready[3]}, 1);
    write_valid[3] = 1'b0;
    do_read(0, 8'h40, 8'h99);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
